vr_packet_arbiter: RTL and testbench

- Round-robin, packet-granular arbiter that lets NUM_IN valid-ready producers share one valid-ready consumer, typically the write side of a shared vr_fifo.
- A grant is held from the first beat to the last beat of a packet, so packets are never interleaved.
- A beat watchdog force-terminates runaway packets.
- Source index is forwarded alongside the data so downstream logic can demultiplex.

---
 rtl/vr_packet_arbiter_if.sv | 63 ++++++
 rtl/vr_packet_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_vr_packet_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vr_packet_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : vr_packet_arbiter_if
// Purpose  : Bundles the NUM_IN valid-ready producer streams and the single
//            valid-ready consumer stream that vr_packet_arbiter sits between.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals:
//   in_data   [NUM_IN*DATA_W] packed producer data, stream i at [i*DATA_W +: DATA_W]
//   in_last   [NUM_IN]        last-beat flag per producer
//   in_valid  [NUM_IN]        valid per producer
//   in_ready  [NUM_IN]        ready per producer (driven by the arbiter)
//   out_data  [DATA_W]        granted stream's data
//   out_last                  last beat of the forwarded packet (natural or forced)
//   out_src   [IDX_W]         index of the granted producer
//   out_valid                 consumer-side valid
//   out_ready                 consumer-side ready
// Modports:
//   master : environment side (producers + consumer)
//   slave  : arbiter side
// ============================================================================
interface vr_packet_arbiter_if #(
  parameter int NUM_IN = 4,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(NUM_IN)
);

  logic [NUM_IN*DATA_W-1:0] in_data;
  logic [NUM_IN-1:0]        in_last;
  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN-1:0]        in_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_last;
  logic [IDX_W-1:0]         out_src;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output in_data,
    output in_last,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_last,
    input  out_src,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  in_data,
    input  in_last,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_last,
    output out_src,
    output out_valid,
    input  out_ready
  );

endinterface
`default_nettype wire

// File: rtl/vr_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vr_packet_arbiter
// Purpose  : Packet-granular round-robin arbiter. NUM_IN valid-ready producers
//            share one valid-ready consumer; a grant is held from the first to
//            the last beat of a packet so packets never interleave. A beat
//            watchdog force-terminates packets longer than MAX_BEATS and sets
//            a sticky overrun flag. The granted index travels with the data.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk       in   clock
//   nrst      in   asynchronous active-low reset
//   en        in   block enable; when low all state is frozen, handshakes off
//   sync_rst  in   synchronous reset, same effect as nrst
//   bus       --   vr_packet_arbiter_if.slave (producer and consumer streams)
//   overrun   out  sticky: at least one packet was force-terminated
// ============================================================================
module vr_packet_arbiter #(
  parameter int NUM_IN    = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 256,
  parameter int IDX_W     = $clog2(NUM_IN),
  parameter int CNT_W     = $clog2(MAX_BEATS)
) (
  input  wire logic             clk,
  input  wire logic             nrst,
  input  wire logic             en,
  input  wire logic             sync_rst,
  vr_packet_arbiter_if.slave    bus,
  output logic                  overrun
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [0:0]       c_st_idle  = 1'b0;
  localparam logic [0:0]       c_st_grant = 1'b1;
  localparam logic [CNT_W-1:0] c_bc_max   = CNT_W'(MAX_BEATS - 1);
  localparam logic [IDX_W-1:0] c_lp_init  = IDX_W'(NUM_IN - 1);

  // --------------------------------------------------------------------------
  // Registers and their next-state values
  // --------------------------------------------------------------------------
  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_g;
  logic [IDX_W-1:0] r_lp;
  logic [CNT_W-1:0] r_bc;
  logic             r_overrun;

  logic [0:0]       w_state_nxt;
  logic [IDX_W-1:0] w_g_nxt;
  logic [IDX_W-1:0] w_lp_nxt;
  logic [CNT_W-1:0] w_bc_nxt;
  logic             w_overrun_nxt;

  // --------------------------------------------------------------------------
  // Round-robin pick: first requester found scanning lp+1, lp+2, ... modulo
  // NUM_IN. The scan runs from the farthest candidate to the nearest so the
  // nearest requester overwrites any earlier hit without needing a break.
  // --------------------------------------------------------------------------
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [IDX_W-1:0]  lp,
    input logic [NUM_IN-1:0] req
  );
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand_idx;
    int               cand;
    pick = '0;
    for (int k = NUM_IN; k >= 1; k--) begin
      cand = int'(lp) + k;
      if (cand >= NUM_IN) begin
        cand = cand - NUM_IN;
      end
      cand_idx = IDX_W'(cand);
      if (req[cand_idx]) begin
        pick = cand_idx;
      end
    end
    return pick;
  endfunction

  // --------------------------------------------------------------------------
  // Per-stream data view and shared combinational terms
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] w_data_arr [NUM_IN];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_unpack
      assign w_data_arr[gi] = bus.in_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  logic             w_is_grant;
  logic             w_active;
  logic             w_sel_valid;
  logic             w_sel_last;
  logic             w_bc_at_max;
  logic             w_beat_last;
  logic             w_beat;
  logic [IDX_W-1:0] w_pick;

  assign w_is_grant  = (r_state == c_st_grant);
  assign w_active    = w_is_grant & en;
  assign w_sel_valid = bus.in_valid[r_g];
  assign w_sel_last  = bus.in_last[r_g];
  assign w_bc_at_max = (r_bc == c_bc_max);
  // Watchdog: the MAX_BEATS-th beat always closes the packet.
  assign w_beat_last = w_sel_last | w_bc_at_max;
  assign w_beat      = w_active & w_sel_valid & bus.out_ready;
  assign w_pick      = rr_pick(r_lp, bus.in_valid);

  // --------------------------------------------------------------------------
  // State register (FSM state plus its datapath registers)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= c_st_idle;
      r_g       <= '0;
      r_lp      <= c_lp_init;
      r_bc      <= '0;
      r_overrun <= 1'b0;
    end else if (sync_rst) begin
      r_state   <= c_st_idle;
      r_g       <= '0;
      r_lp      <= c_lp_init;
      r_bc      <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_g       <= w_g_nxt;
      r_lp      <= w_lp_nxt;
      r_bc      <= w_bc_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. With en low every default holds, which freezes the
  // arbiter mid-packet until en returns.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_g_nxt       = r_g;
    w_lp_nxt      = r_lp;
    w_bc_nxt      = r_bc;
    w_overrun_nxt = r_overrun;
    if (en) begin
      case (r_state)
        c_st_idle: begin
          if (|bus.in_valid) begin
            w_g_nxt     = w_pick;
            w_bc_nxt    = '0;
            w_state_nxt = c_st_grant;
          end
        end
        c_st_grant: begin
          // A stalled producer (in_valid low) simply produces no beat; the
          // grant is only released by a last beat.
          if (w_beat) begin
            if (w_beat_last) begin
              w_lp_nxt    = r_g;
              w_bc_nxt    = '0;
              w_state_nxt = c_st_idle;
              if (w_bc_at_max && !w_sel_last) begin
                w_overrun_nxt = 1'b1;
              end
            end else begin
              w_bc_nxt = r_bc + CNT_W'(1);
            end
          end
        end
        default: begin
          w_state_nxt = c_st_idle;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    bus.in_ready  = '0;
    bus.out_valid = w_active & w_sel_valid;
    bus.out_data  = w_data_arr[r_g];
    bus.out_last  = w_beat_last;
    bus.out_src   = r_g;
    if (w_active && bus.out_ready) begin
      bus.in_ready[r_g] = 1'b1;
    end
  end

  assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_vr_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vr_packet_arbiter
// Purpose  : Directed self-checking bench for vr_packet_arbiter (NUM_IN=4,
//            DATA_W=32, MAX_BEATS=4). Producers are per-stream beat queues;
//            every beat expected on the consumer side is pushed to a
//            scoreboard in predicted arbitration order and compared as it
//            leaves the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vr_packet_arbiter;

  localparam int NUM_IN    = 4;
  localparam int DATA_W    = 32;
  localparam int MAX_BEATS = 4;
  localparam int IDX_W     = 2;

  logic clk = 1'b0;
  logic nrst;
  logic en;
  logic sync_rst;
  logic overrun;

  vr_packet_arbiter_if #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

  vr_packet_arbiter #(
    .NUM_IN   (NUM_IN),
    .DATA_W   (DATA_W),
    .MAX_BEATS(MAX_BEATS),
    .IDX_W    (IDX_W),
    .CNT_W    (2)
  ) dut (
    .clk     (clk),
    .nrst    (nrst),
    .en      (en),
    .sync_rst(sync_rst),
    .bus     (bus),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  src;
    logic              last;
  } beat_t;

  beat_t             sb [$];
  logic [DATA_W:0]   sq [NUM_IN][$];   // {last, data} per producer
  logic [NUM_IN-1:0] hold;
  logic [NUM_IN-1:0] fired;
  logic              ctl_nrst;
  logic              ctl_en;
  logic              ctl_sync_rst;
  logic              ctl_out_ready;
  int                checks;
  int                errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic src_beat(input int s, input logic [DATA_W-1:0] d, input logic l);
    sq[s].push_back({l, d});
  endtask

  task automatic exp_beat(input int s, input logic [DATA_W-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.src  = IDX_W'(s);
    b.last = l;
    sb.push_back(b);
  endtask

  task automatic drive_streams();
    logic [DATA_W:0] h;
    for (int i = 0; i < NUM_IN; i++) begin
      if (fired[i] && sq[i].size() > 0) begin
        sq[i].delete(0);
      end
      if (sq[i].size() > 0 && !hold[i]) begin
        h = sq[i][0];
        bus.in_valid[i]                 = 1'b1;
        bus.in_data[i*DATA_W +: DATA_W] = h[DATA_W-1:0];
        bus.in_last[i]                  = h[DATA_W];
      end else begin
        bus.in_valid[i]                 = 1'b0;
        bus.in_data[i*DATA_W +: DATA_W] = '0;
        bus.in_last[i]                  = 1'b0;
      end
    end
  endtask

  // One clock: inputs change 1ns after the rising edge, outputs are sampled
  // and the scoreboard is consulted on the falling edge.
  task automatic tick();
    beat_t e;
    @(posedge clk);
    #1;
    nrst          = ctl_nrst;
    en            = ctl_en;
    sync_rst      = ctl_sync_rst;
    bus.out_ready = ctl_out_ready;
    drive_streams();
    @(negedge clk);
    fired = bus.in_valid & bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_beat", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        chk("beat_data", 64'(bus.out_data), 64'(e.data));
        chk("beat_src",  64'(bus.out_src),  64'(e.src));
        chk("beat_last", 64'(bus.out_last), 64'(e.last));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    hold          = '0;
    fired         = '0;
    nrst          = 1'b0;
    en            = 1'b1;
    sync_rst      = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = '0;
    bus.in_valid  = '0;
    bus.out_ready = 1'b1;
    ctl_nrst      = 1'b0;
    ctl_en        = 1'b1;
    ctl_sync_rst  = 1'b0;
    ctl_out_ready = 1'b1;

    // ---- reset state ----
    tick();
    tick();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
    chk("rst_overrun",   64'(overrun),       64'd0);
    ctl_nrst = 1'b1;
    tick();

    // ---- 3-beat packet on stream 2, one arbitration cycle ----
    src_beat(2, 32'hA0, 1'b0); exp_beat(2, 32'hA0, 1'b0);
    src_beat(2, 32'hA1, 1'b0); exp_beat(2, 32'hA1, 1'b0);
    src_beat(2, 32'hA2, 1'b1); exp_beat(2, 32'hA2, 1'b1);
    tick();
    chk("t1_arb_valid", 64'(bus.out_valid), 64'd0);
    chk("t1_arb_ready", 64'(bus.in_ready),  64'd0);
    tick();
    chk("t1_first_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_first_src",   64'(bus.out_src),   64'd2);
    tick();
    tick();
    tick();
    chk("t1_idle_after", 64'(bus.out_valid), 64'd0);
    chk("t1_sb_drained", 64'(sb.size()),     64'd0);

    // ---- all streams, 1-beat packets, right after reset ----
    ctl_sync_rst = 1'b1;
    tick();
    ctl_sync_rst = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < NUM_IN; s++) begin
        src_beat(s, 32'hB0 + 32'(r*16 + s), 1'b1);
      end
    end
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < NUM_IN; s++) begin
        exp_beat(s, 32'hB0 + 32'(r*16 + s), 1'b1);
      end
    end
    for (int t = 0; t < 16; t++) begin
      tick();
      chk("t2_alternate_valid", 64'(bus.out_valid), 64'(t % 2));
    end
    chk("t2_sb_drained", 64'(sb.size()), 64'd0);

    // ---- stream 1 stalls mid-packet while stream 0 requests ----
    for (int b = 0; b < 4; b++) begin
      src_beat(1, 32'hD0 + 32'(b), 1'(b == 3));
      exp_beat(1, 32'hD0 + 32'(b), 1'(b == 3));
    end
    tick();
    tick();
    chk("t3_grant_src", 64'(bus.out_src), 64'd1);
    tick();
    src_beat(0, 32'hE0, 1'b1);
    exp_beat(0, 32'hE0, 1'b1);
    hold[1] = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("t3_gap_valid",  64'(bus.out_valid),   64'd0);
      chk("t3_gap_ready0", 64'(bus.in_ready[0]), 64'd0);
    end
    hold[1] = 1'b0;
    tick();
    chk("t3_resume_src", 64'(bus.out_src), 64'd1);
    tick();
    tick();
    chk("t3_idle_between", 64'(bus.out_valid), 64'd0);
    tick();
    chk("t3_other_src", 64'(bus.out_src), 64'd0);
    chk("t3_sb_drained", 64'(sb.size()), 64'd0);

    // ---- runaway packet on stream 3: watchdog at beat 4 ----
    // Producer last only on the sixth beat; the fourth is forced last.
    for (int b = 0; b < 6; b++) begin
      src_beat(3, 32'hF0 + 32'(b), 1'(b == 5));
      exp_beat(3, 32'hF0 + 32'(b), 1'(b == 3 || b == 5));
    end
    tick();
    tick();
    tick();
    tick();
    tick();
    chk("t4_forced_last", 64'(bus.out_last), 64'd1);
    chk("t4_ovr_before",  64'(overrun),      64'd0);
    tick();
    chk("t4_release_valid", 64'(bus.out_valid), 64'd0);
    chk("t4_ovr_set",       64'(overrun),       64'd1);
    tick();
    chk("t4_regrant_src", 64'(bus.out_src), 64'd3);
    tick();
    tick();
    chk("t4_ovr_sticky", 64'(overrun),  64'd1);
    chk("t4_sb_drained", 64'(sb.size()), 64'd0);

    // ---- out_ready toggling on a 4-beat packet ----
    for (int b = 0; b < 4; b++) begin
      src_beat(2, 32'h60 + 32'(b), 1'(b == 3));
      exp_beat(2, 32'h60 + 32'(b), 1'(b == 3));
    end
    tick();
    for (int k = 0; k < 7; k++) begin
      ctl_out_ready = 1'((k % 2) == 0);
      tick();
      chk("t5_valid_held", 64'(bus.out_valid),   64'd1);
      chk("t5_ready_gate", 64'(bus.in_ready[2]), 64'(ctl_out_ready));
    end
    ctl_out_ready = 1'b1;
    tick();
    chk("t5_idle_after", 64'(bus.out_valid), 64'd0);
    chk("t5_sb_drained", 64'(sb.size()),     64'd0);

    // ---- en low mid-packet, then sync_rst ----
    for (int b = 0; b < 4; b++) begin
      src_beat(1, 32'h70 + 32'(b), 1'(b == 3));
    end
    exp_beat(1, 32'h70, 1'b0);
    tick();
    tick();
    chk("t6_grant_src", 64'(bus.out_src), 64'd1);
    ctl_en = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("t6_dis_valid", 64'(bus.out_valid), 64'd0);
      chk("t6_dis_ready", 64'(bus.in_ready),  64'd0);
    end
    ctl_sync_rst = 1'b1;
    tick();
    chk("t6_rst_valid", 64'(bus.out_valid), 64'd0);
    ctl_sync_rst = 1'b0;
    ctl_en       = 1'b1;
    sq[1].delete();
    src_beat(0, 32'h80, 1'b1); exp_beat(0, 32'h80, 1'b1);
    src_beat(3, 32'h83, 1'b1); exp_beat(3, 32'h83, 1'b1);
    tick();
    chk("t6_post_rst_valid",   64'(bus.out_valid), 64'd0);
    chk("t6_post_rst_overrun", 64'(overrun),       64'd0);
    tick();
    chk("t6_priority_src", 64'(bus.out_src), 64'd0);
    for (int t = 0; t < 8 && sb.size() > 0; t++) begin
      tick();
    end
    chk("t6_sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
